// File: rtl/t_toggle_decoder.sv
// Receive-side decoder for a toggle-encoded event link: every level change on t_in
// becomes one event pulse, bumps a wrapping total counter and queues into a saturating
// pending counter drained by a valid/ready consumer.
// Optional build macro: T_TOGGLE_DEC_SYNC_EN adds a two-flop synchronizer on t_in.
module t_toggle_decoder #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              t_in,
    output logic              evt_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    output logic              o_dbg_state
);

    // Handshake: one event leaves the pending queue on every rising clk edge where
    // evt_valid and evt_ready are both high; evt_valid never depends on evt_ready.

`ifdef T_TOGGLE_DEC_SYNC_EN
    localparam logic [1:0] PRIME_LAST = 2'd2;
`else
    localparam logic [1:0] PRIME_LAST = 2'd1;
`endif
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_prime_cnt;
    logic [1:0]        w_prime_cnt_nxt;

    logic              r_sy1;
`ifdef T_TOGGLE_DEC_SYNC_EN
    logic              r_sy2;
`endif
    logic              r_last;
    logic              r_pulse;
    logic [PEND_W-1:0] r_pending;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_s;
    logic              w_edge;
    logic              w_evt;
    logic              w_deq;
    logic              w_pend_max;

`ifdef T_TOGGLE_DEC_SYNC_EN
    assign w_s = r_sy2;
`else
    assign w_s = r_sy1;
`endif

    assign w_edge     = w_s ^ r_last;
    assign w_evt      = w_edge & (r_state == ST_RUN);
    assign w_deq      = evt_valid & evt_ready;
    assign w_pend_max = (r_pending == {PEND_W{1'b1}});

    // PRIME lets the sampling stages and last settle on the idle level, so whatever
    // t_in held through clr is never mistaken for an event.
    always_comb begin
        w_state_nxt     = r_state;
        w_prime_cnt_nxt = r_prime_cnt;
        case (r_state)
            ST_PRIME: begin
                if (r_prime_cnt == PRIME_LAST) begin
                    w_state_nxt     = ST_RUN;
                    w_prime_cnt_nxt = 2'd0;
                end else begin
                    w_prime_cnt_nxt = r_prime_cnt + 2'd1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt     = ST_PRIME;
                w_prime_cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_PRIME;
            r_prime_cnt <= 2'd0;
            r_sy1       <= 1'b0;
`ifdef T_TOGGLE_DEC_SYNC_EN
            r_sy2       <= 1'b0;
`endif
            r_last      <= 1'b0;
            r_pulse     <= 1'b0;
            r_pending   <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prime_cnt <= w_prime_cnt_nxt;
            r_sy1       <= t_in;
`ifdef T_TOGGLE_DEC_SYNC_EN
            r_sy2       <= r_sy1;
`endif
            r_last      <= w_s;
            r_pulse     <= w_evt;
            if (w_evt) begin
                r_count <= r_count + CNT_ONE;
            end
            // A simultaneous arrival and departure cancel out, even when saturated.
            case ({w_evt, w_deq})
                2'b10: begin
                    if (w_pend_max) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pending <= r_pending + PEND_ONE;
                    end
                end
                2'b01:   r_pending <= r_pending - PEND_ONE;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign evt_pulse   = r_pulse;
    assign evt_valid   = (r_pending != '0);
    assign pending     = r_pending;
    assign evt_count   = r_count;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Bench for t_toggle_decoder: a table of directed settle-point vectors, hand-written
// corner sequences and random traffic, all checked every cycle against a history model.
module tb_t_toggle_decoder;

`ifdef T_TOGGLE_DEC_SYNC_EN
    localparam int LAT = 3;
    localparam int PRIME = 3;
`else
    localparam int LAT = 2;
    localparam int PRIME = 2;
`endif
    localparam int PEND_MAX = 15;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       t_in = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pending;
    logic [7:0] evt_count;
    logic       overflow;
    logic       dbg_state;

    t_toggle_decoder #(.CNT_W(8), .PEND_W(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .t_in        (t_in),
        .evt_pulse   (evt_pulse),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .pending     (pending),
        .evt_count   (evt_count),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remembers every t_in value sampled since clr and decides at each
    // edge k whether the samples taken LAT-1 and LAT edges earlier differ.
    int   k     = 0;
    int   clr_k = 0;
    logic samp [8];
    int   m_pend = 0;
    int   m_cnt  = 0;
    logic m_ovf  = 1'b0;
    logic m_pulse = 1'b0;
    logic cur_t  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    task automatic model_edge(input logic c, input logic t, input logic r);
        logic ev;
        logic deq;
        if (c) begin
            clr_k   = k;
            m_pend  = 0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_pulse = 1'b0;
            samp[k % 8] = 1'b0;
        end else begin
            samp[k % 8] = t;
            ev  = (k >= clr_k + PRIME + 1) && (samp[(k - LAT + 1) % 8] != samp[(k - LAT) % 8]);
            deq = (m_pend != 0) && r;
            m_pulse = ev;
            if (ev) m_cnt = (m_cnt + 1) % 256;
            if (ev && !deq) begin
                if (m_pend == PEND_MAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (!ev && deq) begin
                m_pend--;
            end
        end
        k++;
    endtask

    task automatic cycle(input logic c, input logic t, input logic r);
        clr = c;
        t_in = t;
        evt_ready = r;
        @(posedge clk);
        model_edge(c, t, r);
        @(negedge clk);
        check("evt_pulse", 32'(evt_pulse), 32'(m_pulse));
        check("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
        check("pending",   32'(pending),   32'(m_pend));
        check("evt_count", 32'(evt_count), 32'(m_cnt));
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic hold(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(1'b0, cur_t, r);
    endtask

    task automatic do_clr();
        cycle(1'b1, cur_t, 1'b0);
    endtask

    typedef struct {
        logic clr;
        logic t;
        logic rdy;
        int   n;
        logic chk;
        int   exp_cnt;
        int   exp_pend;
        logic exp_ovf;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 2,  1'b1, 0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 0, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 5,  1'b1, 1, 1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 1, 0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 0, 0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 0, 0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5,  1'b1, 4, 3, 1'b0};

        for (int i = 0; i < 7; i++) begin
            cur_t = tbl[i].t;
            for (int j = 0; j < tbl[i].n; j++) cycle(tbl[i].clr, tbl[i].t, tbl[i].rdy);
            if (tbl[i].chk) begin
                check("tbl_count", 32'(evt_count), 32'(tbl[i].exp_cnt));
                check("tbl_pend",  32'(pending),   32'(tbl[i].exp_pend));
                check("tbl_ovf",   32'(overflow),  32'(tbl[i].exp_ovf));
            end
        end

        // Saturation: 16 back-to-back toggles with no consumer.
        do_clr();
        hold(5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cur_t = ~cur_t;
            cycle(1'b0, cur_t, 1'b0);
        end
        hold(4, 1'b0);
        check("sat_count", 32'(evt_count), 32'd16);
        check("sat_pend",  32'(pending),   32'd15);
        check("sat_ovf",   32'(overflow),  32'd1);

        // Toggle lands in the same cycle as a dequeue while saturated.
        cur_t = ~cur_t;
        cycle(1'b0, cur_t, 1'b0);
        hold(LAT - 2, 1'b0);
        cycle(1'b0, cur_t, 1'b1);
        hold(4, 1'b0);
        check("simul_pend",  32'(pending),   32'd15);
        check("simul_ovf",   32'(overflow),  32'd1);
        check("simul_count", 32'(evt_count), 32'd17);

        // Drain to 5, then clr mid-operation and re-prime.
        hold(10, 1'b1);
        check("drain_pend", 32'(pending), 32'd5);
        do_clr();
        check("clr_count", 32'(evt_count), 32'd0);
        check("clr_pend",  32'(pending),   32'd0);
        check("clr_ovf",   32'(overflow),  32'd0);
        check("clr_valid", 32'(evt_valid), 32'd0);
        check("clr_pulse", 32'(evt_pulse), 32'd0);
        cur_t = ~cur_t;
        cycle(1'b0, cur_t, 1'b0);
        hold(5, 1'b0);
        check("reprime_count", 32'(evt_count), 32'd0);
        cur_t = ~cur_t;
        hold(5, 1'b0);
        check("postprime_count", 32'(evt_count), 32'd1);
        check("postprime_pend",  32'(pending),   32'd1);

        // Counter wrap: 257 toggles with the consumer always ready.
        do_clr();
        hold(5, 1'b1);
        for (int i = 0; i < 257; i++) begin
            cur_t = ~cur_t;
            cycle(1'b0, cur_t, 1'b1);
            check("wrap_pend_le1", 32'(pending <= 4'd1), 32'd1);
        end
        hold(5, 1'b1);
        check("wrap_count", 32'(evt_count), 32'd1);
        check("wrap_ovf",   32'(overflow),  32'd0);
        check("wrap_pend",  32'(pending),   32'd0);

        // Random traffic with occasional clr.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) cur_t = ~cur_t;
            cycle(($urandom_range(0, 63) == 0), cur_t, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/t_toggle_decoder.md
# t_toggle_decoder

Receive-side decoder for toggle-encoded events. The sender drives a level that a T flip-flop with clear inverts once per event. This block samples that level, turns every transition into one single-cycle event pulse, counts events, and queues them in a pending counter for a valid/ready consumer. It sits at the far end of the toggle link, opposite the T flip-flop.

## Interface
- CNT_W, 8, width of the wrapping total-event counter
- PEND_W, 4, width of the saturating pending-event counter (max 2^PEND_W−1)

- clk  in  1  system clock, rising edge
- clr  in  1  reset, synchronous, active-high
- t_in  in  1  toggle-encoded level (T flip-flop q of sender)
- evt_pulse  out  1  one-cycle pulse per decoded transition
- evt_valid  out  1  pending ≠ 0
- evt_ready  in  1  consumer accepts one event when evt_valid & evt_ready
- pending  out  PEND_W  events decoded but not yet accepted
- evt_count  out  CNT_W  total events decoded since clr, modulo 2^CNT_W
- overflow  out  1  sticky; an event arrived while pending was saturated

## Operation
- Input path: t_in → sampling stage(s) → s. Register `last` holds the previous s. Transition detect: edge = s ^ last.
- FSM states:
  - PRIME: entered on clr. `last` ← s every cycle. edge ignored. A counter runs for PRIME_CYC cycles (3 with sync, 2 without), then moves to RUN.
  - RUN: `last` ← s every cycle. On edge: evt_pulse=1 next cycle, evt_count+1, pending update below.
- Pending update per cycle, with deq = evt_valid & evt_ready:
  - edge & !deq: pending+1. If pending already = max, pending holds and overflow←1.
  - !edge & deq: pending−1.
  - edge & deq: pending unchanged, no overflow, even at max.
  - otherwise hold.
- evt_valid is combinational from pending ≠ 0. evt_ready with pending=0 has no effect.
- evt_count wraps from 2^CNT_W−1 to 0. Wrapping does not set overflow.
- overflow clears only on clr.
- An edge is allowed every cycle. Back-to-back transitions each produce a pulse, so evt_pulse stays high for N cycles for N consecutive edges.
- Level transitions on t_in during PRIME are absorbed and never counted.

## Timing
- Reset values: all outputs 0, state PRIME, sampling stages 0, last 0, prime counter 0.
- clr asserted at any edge, including mid-operation, forces reset values at that edge. pending and overflow are discarded. The FSM re-primes.
- Latency with the synchronizer: t_in changes before edge E0; sy1 captures at E0; sy2 at E1; edge is valid after E1. At E2, evt_pulse, evt_count and pending update. evt_valid rises after E2.
- Latency without the synchronizer: one stage. Outputs update at E1.
- First countable transition: t_in must change after the last PRIME cycle, i.e. sampled at or after clr-release edge + PRIME_CYC.
- Dequeue takes effect at the edge where evt_valid & evt_ready is seen. pending drops after that edge.

## Configuration
- T_TOGGLE_DEC_SYNC_EN defined: two-flop synchronizer (sy1, sy2) for an asynchronous t_in. PRIME_CYC=3. Event latency is 3 edges counting the sampling edge.
- Not defined: single input register. t_in is assumed synchronous to clk. PRIME_CYC=2. Event latency is 2 edges.

## Test plan
- Hold t_in=1 through clr, release clr, wait 10 cycles → evt_pulse never 1, evt_count=0, pending=0.
- After prime, toggle t_in 0→1 once, evt_ready=0 → exactly one evt_pulse at the specified latency, evt_count=1, pending=1, evt_valid=1. Then evt_ready=1 for one cycle → pending=0, evt_valid=0.
- Toggle t_in on 3 consecutive cycles (0→1→0→1), evt_ready=0 → evt_pulse high 3 consecutive cycles, evt_count=3, pending=3.
- With evt_ready=0, apply 16 toggles (PEND_W=4) → pending saturates at 15, overflow=1, evt_count=16. With pending=15, apply a toggle in the same cycle as a dequeue → pending stays 15, overflow unchanged.
- Apply 257 toggles with evt_ready=1 → evt_count=1 after wrap, overflow=0, pending≤1.
- With pending=5 and overflow=1, assert clr for one cycle → all outputs 0 at the next edge. A toggle during re-prime is not counted. A toggle after prime gives evt_count=1.
